// File: rtl/fft_stage_controller_if.sv
// RAM / twiddle ROM / butterfly handshake bundle for fft_stage_controller.
interface fft_stage_controller_if #(
  parameter int unsigned LOG2N = 10
);
  logic             o_rd_en;
  logic [LOG2N-1:0] o_rd_addr_a;
  logic [LOG2N-1:0] o_rd_addr_b;
  logic             o_tw_en;
  logic [LOG2N-2:0] o_tw_addr;
  logic             o_bfly_start;
  logic             i_bfly_valid;
  logic             o_wr_en;
  logic [LOG2N-1:0] o_wr_addr_a;
  logic [LOG2N-1:0] o_wr_addr_b;

  modport master (
    output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_en, o_tw_addr, o_bfly_start,
    output o_wr_en, o_wr_addr_a, o_wr_addr_b,
    input  i_bfly_valid
  );

  modport slave (
    input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_en, o_tw_addr, o_bfly_start,
    input  o_wr_en, o_wr_addr_a, o_wr_addr_b,
    output i_bfly_valid
  );
endinterface

// File: rtl/fft_stage_controller.sv
// In-place radix-2 DIT FFT sequencer: walks LOG2N stages x N/2 butterflies,
// issuing RAM/ROM reads, a butterfly start pulse and the paired RAM write.
module fft_stage_controller #(
  parameter int unsigned N_POINTS     = 1024,
  parameter int unsigned LOG2N        = 10,
  parameter int unsigned BFLY_TIMEOUT = 64  // must be >= 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [$clog2(LOG2N)-1:0] o_stage,
  fft_stage_controller_if.master   bus
);

  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned TW = $clog2(BFLY_TIMEOUT + 1);
  localparam logic [KW-1:0] KLast = KW'(N_POINTS / 2 - 1);
  localparam logic [SW-1:0] SLast = SW'(LOG2N - 1);
  // Counter reads 0 in the first WAIT_BF cycle, so the error flag lands
  // exactly BFLY_TIMEOUT cycles after the start pulse.
  localparam logic [TW-1:0] TLast = TW'(BFLY_TIMEOUT - 2);

  typedef enum logic [2:0] {StIdle, StRead, StStart, StWaitBf, StWrite, StDone} state_e;

  state_e         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [KW-1:0]  k_q, k_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [LOG2N-1:0] wr_a_q, wr_a_d, wr_b_q, wr_b_d;

  logic [LOG2N-1:0] span, jmask, k_ext, addr_a, addr_b;
  logic [KW-1:0]    tw_idx;

  // Butterfly addressing from (s, k) using masks and shifts only.
  always_comb begin
    span   = LOG2N'(1) << s_q;
    jmask  = span - 1'b1;
    k_ext  = {1'b0, k_q};
    // (k & ~mask) is g*span; doubling it gives the group base 2*g*span.
    addr_a = ((k_ext & ~jmask) << 1) | (k_ext & jmask);
    addr_b = addr_a | span;
    tw_idx = KW'((k_ext & jmask) << (SLast - s_q));
  end

  // State and counter registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wr_a_q  <= '0;
      wr_b_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wr_a_q  <= wr_a_d;
      wr_b_q  <= wr_b_d;
    end
  end

  // Next-state logic and strobes; addresses are driven only with their enables.
  always_comb begin
    state_d          = state_q;
    s_d              = s_q;
    k_d              = k_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    wr_a_d           = wr_a_q;
    wr_b_d           = wr_b_q;
    o_busy           = 1'b0;
    o_done           = 1'b0;
    bus.o_rd_en      = 1'b0;
    bus.o_rd_addr_a  = '0;
    bus.o_rd_addr_b  = '0;
    bus.o_tw_en      = 1'b0;
    bus.o_tw_addr    = '0;
    bus.o_bfly_start = 1'b0;
    bus.o_wr_en      = 1'b0;
    bus.o_wr_addr_a  = '0;
    bus.o_wr_addr_b  = '0;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          s_d     = '0;
          k_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StRead;
        end
      end
      StRead: begin
        o_busy          = 1'b1;
        bus.o_rd_en     = 1'b1;
        bus.o_rd_addr_a = addr_a;
        bus.o_rd_addr_b = addr_b;
        bus.o_tw_en     = 1'b1;
        bus.o_tw_addr   = tw_idx;
        wr_a_d          = addr_a;
        wr_b_d          = addr_b;
        state_d         = StStart;
      end
      StStart: begin
        o_busy           = 1'b1;
        bus.o_bfly_start = 1'b1;
        cnt_d            = '0;
        state_d          = StWaitBf;
      end
      StWaitBf: begin
        o_busy = 1'b1;
        if (bus.i_bfly_valid) begin
          state_d = StWrite;
        end else if (cnt_q == TLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        o_busy          = 1'b1;
        bus.o_wr_en     = 1'b1;
        bus.o_wr_addr_a = wr_a_q;
        bus.o_wr_addr_b = wr_b_q;
        if (k_q == KLast) begin
          k_d = '0;
          if (s_q == SLast) begin
            state_d = StDone;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = StRead;
          end
        end else begin
          k_d     = k_q + 1'b1;
          state_d = StRead;
        end
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_error = err_q;
  assign o_stage = s_q;

endmodule

// File: tb/tb_fft_stage_controller.sv
// Directed bench: N=8 sequencing, impulse FFT through a RAM/butterfly model,
// butterfly timeout, ignored starts/valids, async reset abort, N=1024 timing.
module tb_fft_stage_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start8 = 1'b0;
  logic start1k = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- N=8 instance ----------------
  logic       busy8, done8, err8;
  logic [1:0] stage8;
  fft_stage_controller_if #(.LOG2N(3)) bus8 ();
  fft_stage_controller #(.N_POINTS(8), .LOG2N(3), .BFLY_TIMEOUT(16)) dut8 (
    .clk(clk), .reset(reset), .i_start(start8), .o_busy(busy8), .o_done(done8),
    .o_error(err8), .o_stage(stage8), .bus(bus8)
  );

  // Butterfly model: valid exactly BfL cycles after the start pulse.
  localparam int BfL = 3;
  int bf_cnt;
  bit bf_never = 1'b0;
  bit spur_en = 1'b0;
  logic spur_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bf_cnt <= 0;
      spur_q <= 1'b0;
    end else begin
      if (bus8.o_bfly_start) bf_cnt <= 1;
      else if (bf_cnt != 0 && bf_cnt <= BfL) bf_cnt <= bf_cnt + 1;
      else bf_cnt <= 0;
      // Stray valid in the cycle after each write, i.e. during READ or DONE.
      spur_q <= spur_en && bus8.o_wr_en;
    end
  end
  assign bus8.i_bfly_valid = ((bf_cnt == BfL) && !bf_never) || spur_q;

  // RAM (1-cycle read), twiddle ROM (Q10) and reference butterfly.
  int ram_re[8];
  int ram_im[8];
  int tw_re_t[4] = '{1024, 724, 0, -724};
  int tw_im_t[4] = '{0, -724, -1024, -724};
  int da_re, da_im, db_re, db_im, tw_i;
  int ya_re, ya_im, yb_re, yb_im;
  bit ram_load = 1'b1;

  function automatic int cm_re(input int br, input int bi, input int t);
    return (br * tw_re_t[t] - bi * tw_im_t[t]) >>> 10;
  endfunction
  function automatic int cm_im(input int br, input int bi, input int t);
    return (br * tw_im_t[t] + bi * tw_re_t[t]) >>> 10;
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8; i++) begin
        ram_re[i] <= (i == 0) ? 1000 : 0;
        ram_im[i] <= 0;
      end
    end
    if (bus8.o_rd_en) begin
      da_re <= ram_re[bus8.o_rd_addr_a];
      da_im <= ram_im[bus8.o_rd_addr_a];
      db_re <= ram_re[bus8.o_rd_addr_b];
      db_im <= ram_im[bus8.o_rd_addr_b];
      tw_i  <= int'(bus8.o_tw_addr);
    end
    if (bus8.o_bfly_start) begin
      ya_re <= da_re + cm_re(db_re, db_im, tw_i);
      ya_im <= da_im + cm_im(db_re, db_im, tw_i);
      yb_re <= da_re - cm_re(db_re, db_im, tw_i);
      yb_im <= da_im - cm_im(db_re, db_im, tw_i);
    end
    if (bus8.o_wr_en) begin
      ram_re[bus8.o_wr_addr_a] <= ya_re;
      ram_im[bus8.o_wr_addr_a] <= ya_im;
      ram_re[bus8.o_wr_addr_b] <= yb_re;
      ram_im[bus8.o_wr_addr_b] <= yb_im;
    end
  end

  logic [22:0] outs8;
  assign outs8 = {busy8, done8, err8, stage8, bus8.o_rd_en, bus8.o_rd_addr_a, bus8.o_rd_addr_b,
                  bus8.o_tw_en, bus8.o_tw_addr, bus8.o_bfly_start, bus8.o_wr_en,
                  bus8.o_wr_addr_a, bus8.o_wr_addr_b};

  // ---------------- N=1024 instance ----------------
  logic       busy1k, done1k, err1k;
  logic [3:0] stage1k;
  fft_stage_controller_if #(.LOG2N(10)) bus1k ();
  fft_stage_controller dut1k (
    .clk(clk), .reset(reset), .i_start(start1k), .o_busy(busy1k), .o_done(done1k),
    .o_error(err1k), .o_stage(stage1k), .bus(bus1k)
  );

  int bf1k_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) bf1k_cnt <= 0;
    else if (bus1k.o_bfly_start) bf1k_cnt <= 1;
    else bf1k_cnt <= 0;
  end
  assign bus1k.i_bfly_valid = (bf1k_cnt == 1);

  // Expected N=8 butterfly order, stage by stage.
  int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // Full N=8 run; called and returns at a negedge.
  task automatic run8(input string tag, input bit noisy);
    int t0, done_at, n_rd, n_wr;
    int rd_v[12];
    int wr_v[12];
    done_at = -1;
    n_rd = 0;
    n_wr = 0;
    start8 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start8 = 1'b0;
    check_eq({tag, "_busy"}, busy8, 1);
    check_eq({tag, "_err_clr"}, err8, 0);
    for (int i = 0; i < 200; i++) begin
      if (bus8.o_rd_en) begin
        if (n_rd < 12) rd_v[n_rd] = 100 * bus8.o_rd_addr_a + 10 * bus8.o_rd_addr_b + bus8.o_tw_addr;
        n_rd++;
      end
      if (bus8.o_wr_en) begin
        if (n_wr < 12) wr_v[n_wr] = 10 * bus8.o_wr_addr_a + bus8.o_wr_addr_b;
        n_wr++;
      end
      if (done8) begin
        done_at = cyc;
        break;
      end
      if (noisy) start8 = (cyc % 3 == 0);
      @(negedge clk);
    end
    start8 = 1'b0;
    check_eq({tag, "_cycles"}, done_at - t0, 73);
    check_eq({tag, "_n_rd"}, n_rd, 12);
    check_eq({tag, "_n_wr"}, n_wr, 12);
    for (int k = 0; k < 12 && k < n_rd && k < n_wr; k++) begin
      check_eq($sformatf("%s_rd%0d", tag, k), rd_v[k], 100 * exp_a[k] + 10 * exp_b[k] + exp_tw[k]);
      check_eq($sformatf("%s_wr%0d", tag, k), wr_v[k], 10 * exp_a[k] + exp_b[k]);
    end
    if (noisy) begin
      start8 = 1'b1;  // lands in the DONE cycle
      @(negedge clk);
      start8 = 1'b0;
      check_eq({tag, "_done_start_ign"}, busy8, 0);
      @(negedge clk);
      check_eq({tag, "_still_idle"}, {busy8, bus8.o_rd_en}, 0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int t0, bs_at, er_at, n_wr, last_tw, mask, bad, prev, done_at;
    repeat (3) @(negedge clk);
    check_eq("reset8_outs", outs8, 0);
    check_eq("reset1k_outs", {busy1k, done1k, err1k, stage1k, bus1k.o_rd_en, bus1k.o_wr_en}, 0);
    reset = 1'b1;
    ram_load = 1'b0;
    @(negedge clk);

    // Impulse FFT with address/timing checks.
    run8("imp", 1'b0);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("bin%0d_re", i), ram_re[i], 1000);
      check_eq($sformatf("bin%0d_im", i), ram_im[i], 0);
    end

    // Butterfly never answers.
    bf_never = 1'b1;
    bs_at = -1;
    er_at = -1;
    n_wr = 0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus8.o_bfly_start && bs_at < 0) bs_at = cyc;
      if (bus8.o_wr_en) n_wr++;
      if (err8) begin
        er_at = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq("to_latency", er_at - bs_at, 16);
    check_eq("to_busy", busy8, 0);
    repeat (3) begin
      @(negedge clk);
      if (bus8.o_wr_en) n_wr++;
    end
    check_eq("to_no_write", n_wr, 0);
    check_eq("to_sticky", {err8, busy8}, 2'b10);
    bf_never = 1'b0;
    run8("after_to", 1'b0);

    // Repeated starts and stray valids must not disturb the run.
    spur_en = 1'b1;
    run8("noisy", 1'b1);
    spur_en = 1'b0;

    // Asynchronous reset during stage 1 WAIT_BF.
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (stage8 == 2'd1 && busy8 && !bus8.o_rd_en && !bus8.o_bfly_start && !bus8.o_wr_en) break;
      @(negedge clk);
    end
    check_eq("rst_reached_s1_wait", {stage8, busy8}, 3'b011);
    #2 reset = 1'b0;
    #1 check_eq("rst_async_outs", outs8, 0);
    n_wr = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus8.o_wr_en) n_wr++;
    end
    check_eq("rst_no_write", n_wr, 0);
    reset = 1'b1;
    @(negedge clk);
    run8("post_rst", 1'b0);

    // Default N=1024, L=1.
    done_at = -1;
    last_tw = -1;
    n_wr = 0;
    mask = 0;
    bad = 0;
    prev = 0;
    start1k = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start1k = 1'b0;
    for (int i = 0; i < 21000; i++) begin
      mask |= 1 << stage1k;
      if (int'(stage1k) != prev) begin
        if (int'(stage1k) != prev + 1) bad++;
        prev = int'(stage1k);
      end
      if (bus1k.o_rd_en && stage1k == 4'd9) last_tw = int'(bus1k.o_tw_addr);
      if (bus1k.o_wr_en) n_wr++;
      if (done1k) begin
        done_at = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq("1k_cycles", done_at - t0, 20481);
    check_eq("1k_stage_mask", mask, 32'h3FF);
    check_eq("1k_stage_order", bad, 0);
    check_eq("1k_last_tw", last_tw, 511);
    check_eq("1k_n_wr", n_wr, 5120);
    check_eq("1k_err", err1k, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
